// File: rtl/decode_scan_pkg.sv
// Shared types for the decode_scan block: command mode encoding and FSM states.
package decode_scan_pkg;

  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 6;
  localparam int DWELL_W   = 4;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_CLEAR     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_SCAN  = 2'b10
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational binary-to-one-hot decoder; polarity and registering live in the parent.
module onehot_dec #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] code
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    code      = '0;
    code[idx] = 1'b1;
  end

endmodule

// File: rtl/decode_scan.sv
// Registered one-hot decoder with direct, scan-up/down and clear commands.
// A scan holds each index dwell+1 cycles and can be stopped into DRIVE.
module decode_scan
  import decode_scan_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               stop,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               wrap
);

  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel_w
    $error("decode_scan: SEL_W out of range 1..6");
  end

  localparam logic [OUT_W-1:0] POLARITY = {OUT_W{ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};

  state_e             state, state_next;
  logic [SEL_W-1:0]   idx_next;
  logic               valid_next;
  logic               wrap_next;
  logic [DWELL_W-1:0] cnt, cnt_next;
  logic [DWELL_W-1:0] dwell_q, dwell_next;
  logic               up_q, up_next;
  logic [OUT_W-1:0]   code_next;

  assign in_ready = (state != ST_SCAN);

  always_comb begin
    state_next = state;
    idx_next   = cur_idx;
    valid_next = out_valid;
    wrap_next  = 1'b0;
    cnt_next   = cnt;
    dwell_next = dwell_q;
    up_next    = up_q;

    unique case (state)
      ST_IDLE, ST_DRIVE: begin
        if (in_valid) begin
          unique case (mode_e'(mode))
            MODE_DIRECT: begin
              state_next = ST_DRIVE;
              idx_next   = sel;
              valid_next = 1'b1;
            end
            MODE_SCAN_UP, MODE_SCAN_DOWN: begin
              state_next = ST_SCAN;
              idx_next   = sel;
              valid_next = 1'b1;
              cnt_next   = '0;
              dwell_next = dwell;
              up_next    = (mode_e'(mode) == MODE_SCAN_UP);
            end
            MODE_CLEAR: begin
              state_next = ST_IDLE;
              idx_next   = '0;
              valid_next = 1'b0;
              cnt_next   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SCAN: begin
        // stop has priority over a step that falls on the same cycle
        if (stop) begin
          state_next = ST_DRIVE;
          cnt_next   = '0;
        end else if (cnt == dwell_q) begin
          cnt_next = '0;
          if (up_q) begin
            idx_next  = cur_idx + 1'b1;
            wrap_next = (cur_idx == IDX_MAX);
          end else begin
            idx_next  = cur_idx - 1'b1;
            wrap_next = (cur_idx == '0);
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
        valid_next = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx  (idx_next),
    .code (code_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      dwell_q   <= '0;
      up_q      <= 1'b0;
      out       <= POLARITY;
    end else begin
      state     <= state_next;
      cur_idx   <= idx_next;
      out_valid <= valid_next;
      wrap      <= wrap_next;
      cnt       <= cnt_next;
      dwell_q   <= dwell_next;
      up_q      <= up_next;
      out       <= valid_next ? (code_next ^ POLARITY) : POLARITY;
    end
  end

endmodule

// File: doc/decode_scan.md
DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 Parameter SEL_W, default 3, select width; SHALL be 1..6.
REQ-002 Derived constant OUT_W = 2**SEL_W, output width; not overridable.
REQ-003 Parameter ACTIVE_LOW, default 0; when 1, out SHALL be the bitwise inverse of the one-hot code.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  command present.
REQ-007 in_ready  out  1  block can accept a command.
REQ-008 mode  in  2  00 direct, 01 scan-up, 10 scan-down, 11 clear.
REQ-009 sel  in  SEL_W  direct index or scan start index.
REQ-010 dwell  in  4  extra cycles per scan step (step length dwell+1).
REQ-011 stop  in  1  terminates an active scan.
REQ-012 out  out  OUT_W  registered one-hot (or inverted) code.
REQ-013 out_valid  out  1  out holds a decoded index.
REQ-014 cur_idx  out  SEL_W  index currently driven.
REQ-015 wrap  out  1  one-cycle pulse on scan index wrap-around.

Function
REQ-016 FSM states IDLE, DRIVE, SCAN; a command SHALL be accepted only when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 in IDLE and DRIVE, 0 in SCAN.
REQ-018 Direct accepted in cycle N: out = onehot(sel), cur_idx = sel, out_valid = 1 from cycle N+1; state DRIVE; value held until next command.
REQ-019 Scan accepted in cycle N: sel and dwell captured; out = onehot(sel) from N+1; state SCAN.
REQ-020 In SCAN, each index SHALL be held exactly dwell+1 cycles, then cur_idx steps +1 (up) or -1 (down) modulo OUT_W.
REQ-021 wrap SHALL be 1 for exactly the first cycle out shows index 0 after OUT_W-1 (up) or index OUT_W-1 after 0 (down); never in DRIVE.
REQ-022 stop in SCAN: next cycle state DRIVE, index unchanged, in_ready 1; if stop coincides with a step boundary, stop wins and no step occurs.
REQ-023 stop outside SCAN SHALL be ignored.
REQ-024 Clear accepted: next cycle out = inactive value, out_valid 0, cur_idx 0, state IDLE.
REQ-025 Inactive out value SHALL be all zeros (ACTIVE_LOW=0) or all ones (ACTIVE_LOW=1); exactly one bit active whenever out_valid = 1.

Reset
REQ-026 rst_n low at a rising edge SHALL force: state IDLE, out inactive value, out_valid 0, cur_idx 0, wrap 0, dwell counter 0, in_ready 1.
REQ-027 Reset mid-scan SHALL abandon the scan; no resumption after rst_n returns high.

Structure
REQ-028 Shared package decode_scan_pkg SHALL hold the mode encoding and FSM state typedefs.
REQ-029 Combinational sub-module onehot_dec (SEL_W in, OUT_W out) SHALL perform decoding; polarity and registering stay in decode_scan.

Verification (SEL_W=3)
REQ-030 Reset: rst_n low 2 cycles -> out=00000000, out_valid 0, in_ready 1, wrap 0.
REQ-031 Direct sweep sel 0..7 -> one cycle later out = 00000001..10000000, out_valid 1, cur_idx = sel.
REQ-032 Scan-up sel=6 dwell=1 -> 01000000 x2, 10000000 x2, 00000001 with wrap=1 first cycle only, in_ready 0 throughout.
REQ-033 Scan-down sel=0 dwell=0 -> 00000001, 10000000 (wrap=1), 01000000; stop on a step boundary -> index held, in_ready 1 next cycle.
REQ-034 ACTIVE_LOW=1 direct sel=2 -> out=11111011; then clear -> 11111111, out_valid 0.
REQ-035 rst_n low mid-scan -> reset values next edge; out stays static after rst_n released with no command.
